// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked ALU with status flags.
// Single-cycle ops finish one cycle after accept. MUL (shift-add) and DIV
// (restoring) iterate once per bit, then hold the result until it is consumed.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             zf,
  output logic             cf,
  output logic             vf,
  output logic             nf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);
  localparam int M   = WIDTH - 1;
  localparam logic [SHW-1:0]   CNT_INIT = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_NAND = 4'd6;
  localparam logic [3:0] OP_NOR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;
  localparam logic [3:0] OP_ASR  = 4'd10;
  localparam logic [3:0] OP_CMP  = 4'd11;
  localparam logic [3:0] OP_INC  = 4'd12;
  localparam logic [3:0] OP_DEC  = 4'd13;
  localparam logic [3:0] OP_MUL  = 4'd14;
  localparam logic [3:0] OP_DIV  = 4'd15;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state, state_nx;

  logic             accept;
  logic             is_multi;
  logic [SHW-1:0]   cnt;
  logic             mul_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi;   // MUL accumulator / DIV partial remainder
  logic [WIDTH-1:0] lo;   // MUL multiplier (becomes low product) / DIV dividend (becomes quotient)
  logic [WIDTH-1:0] hi_nx, lo_nx;

  // single-cycle result path
  logic [WIDTH-1:0] s_r, s_hi;
  logic             s_zf, s_cf, s_vf, s_nf, s_err;
  logic [WIDTH-1:0] add_rhs, sub_rhs;
  logic [WIDTH:0]   sum_w, dif_w, shl_w, shr_w, asr_w;
  logic [SHW-1:0]   sh;

  assign accept   = in_valid && in_ready;
  // DIV by zero is resolved immediately and never enters the iterative path
  assign is_multi = (op == OP_MUL) || ((op == OP_DIV) && (b != '0));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = is_multi ? BUSY : DONE;
      BUSY:    if (cnt == '0) state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Single-cycle ALU; shifts use one extra bit to catch the bit shifted out
  always_comb begin
    add_rhs = (op == OP_INC) ? ONE : b;
    sub_rhs = (op == OP_DEC) ? ONE : b;
    sum_w   = {1'b0, a} + {1'b0, add_rhs};
    dif_w   = {1'b0, a} - {1'b0, sub_rhs};
    sh      = b[SHW-1:0];
    shl_w   = {1'b0, a} << sh;
    shr_w   = {a, 1'b0} >> sh;
    asr_w   = $unsigned($signed({a, 1'b0}) >>> sh);
    s_r     = '0;
    s_hi    = '0;
    s_cf    = 1'b0;
    s_vf    = 1'b0;
    s_err   = 1'b0;
    case (op)
      OP_ADD, OP_INC: begin
        s_r  = sum_w[WIDTH-1:0];
        s_cf = sum_w[WIDTH];
        s_vf = (a[M] == add_rhs[M]) && (sum_w[M] != a[M]);
      end
      OP_SUB, OP_DEC: begin
        s_r  = dif_w[WIDTH-1:0];
        s_cf = dif_w[WIDTH];
        s_vf = (a[M] != sub_rhs[M]) && (dif_w[M] != a[M]);
      end
      OP_AND:  s_r = a & b;
      OP_OR:   s_r = a | b;
      OP_XOR:  s_r = a ^ b;
      OP_NOT:  s_r = ~a;
      OP_NAND: s_r = ~(a & b);
      OP_NOR:  s_r = ~(a | b);
      OP_SHL: begin
        s_r  = shl_w[WIDTH-1:0];
        s_cf = shl_w[WIDTH];
      end
      OP_SHR: begin
        s_r  = shr_w[WIDTH:1];
        s_cf = shr_w[0];
      end
      OP_ASR: begin
        s_r  = asr_w[WIDTH:1];
        s_cf = asr_w[0];
      end
      OP_CMP: begin
        s_r[0] = dif_w[WIDTH];
        s_cf   = dif_w[WIDTH];
      end
      OP_DIV: begin
        // only reached here with b == 0
        s_r   = '1;
        s_hi  = a;
        s_err = 1'b1;
      end
      default: ;
    endcase
    s_zf = (s_r == '0);
    s_nf = s_r[M];
  end

  // One iteration step of shift-add multiply or restoring divide
  always_comb begin
    logic [WIDTH:0] msum;
    logic [WIDTH:0] dsh;
    logic [WIDTH:0] ddif;
    msum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    dsh   = {hi, lo[M]};
    ddif  = dsh - {1'b0, b_q};
    hi_nx = hi;
    lo_nx = lo;
    if (mul_q) begin
      hi_nx = msum[WIDTH:1];
      lo_nx = {msum[0], lo[WIDTH-1:1]};
    end else if (!ddif[WIDTH]) begin
      hi_nx = ddif[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nx = dsh[WIDTH-1:0];
      lo_nx = {lo[WIDTH-2:0], 1'b0};
    end
  end

  // Operand capture, iteration registers and result/flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      mul_q <= 1'b0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      r     <= '0;
      r_hi  <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
      vf    <= 1'b0;
      nf    <= 1'b0;
      err   <= 1'b0;
    end else if (accept) begin
      if (is_multi) begin
        // results stay as they were until the last iteration lands
        cnt   <= CNT_INIT;
        mul_q <= (op == OP_MUL);
        b_q   <= b;
        hi    <= '0;
        lo    <= a;
      end else begin
        r    <= s_r;
        r_hi <= s_hi;
        zf   <= s_zf;
        cf   <= s_cf;
        vf   <= s_vf;
        nf   <= s_nf;
        err  <= s_err;
      end
    end else if (state == BUSY) begin
      hi <= hi_nx;
      lo <= lo_nx;
      if (cnt == '0) begin
        r    <= lo_nx;
        r_hi <= hi_nx;
        zf   <= (lo_nx == '0);
        cf   <= mul_q && (hi_nx != '0);
        vf   <= 1'b0;
        nf   <= lo_nx[M];
        err  <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table for single-cycle ops,
// plus hand sequences for MUL/DIV latency, backpressure and async reset.
module tb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic [3:0] op = '0;
  logic       in_ready, out_valid;
  logic [7:0] r, r_hi;
  logic       zf, cf, vf, nf, err;

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .r_hi(r_hi), .zf(zf), .cf(cf), .vf(vf), .nf(nf), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a, b, r, rh;
    logic       zf, cf, vf, nf, err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // present an operation for one edge; returns at the following negedge (cycle 1)
  task automatic do_accept(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
    @(negedge clk);
    chk("in_ready_before_accept", 16'(in_ready), 16'd1);
    in_valid = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // consume the pending result and confirm the block is ready again
  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_release", 16'(in_ready), 16'd1);
    chk("out_valid_after_release", 16'(out_valid), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    n_err++;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    //                op     a      b      r      rh     zf cf vf nf err
    vecs.push_back('{4'd0,  8'hE1, 8'hC8, 8'hA9, 8'h00, 0, 1, 0, 1, 0});
    vecs.push_back('{4'd1,  8'hE1, 8'hC8, 8'h19, 8'h00, 0, 0, 0, 0, 0});
    vecs.push_back('{4'd2,  8'hE1, 8'hC8, 8'hC0, 8'h00, 0, 0, 0, 1, 0});
    vecs.push_back('{4'd3,  8'hE1, 8'hC8, 8'hE9, 8'h00, 0, 0, 0, 1, 0});
    vecs.push_back('{4'd4,  8'hE1, 8'hC8, 8'h29, 8'h00, 0, 0, 0, 0, 0});
    vecs.push_back('{4'd5,  8'hE1, 8'hC8, 8'h1E, 8'h00, 0, 0, 0, 0, 0});
    vecs.push_back('{4'd6,  8'hE1, 8'hC8, 8'h3F, 8'h00, 0, 0, 0, 0, 0});
    vecs.push_back('{4'd7,  8'hE1, 8'hC8, 8'h16, 8'h00, 0, 0, 0, 0, 0});
    vecs.push_back('{4'd8,  8'hE1, 8'hC8, 8'hE1, 8'h00, 0, 0, 0, 1, 0});
    vecs.push_back('{4'd9,  8'hE1, 8'hC8, 8'hE1, 8'h00, 0, 0, 0, 1, 0});
    vecs.push_back('{4'd10, 8'hE1, 8'hC8, 8'hE1, 8'h00, 0, 0, 0, 1, 0});
    vecs.push_back('{4'd11, 8'hE1, 8'hC8, 8'h00, 8'h00, 1, 0, 0, 0, 0});
    vecs.push_back('{4'd12, 8'hE1, 8'hC8, 8'hE2, 8'h00, 0, 0, 0, 1, 0});
    vecs.push_back('{4'd13, 8'hE1, 8'hC8, 8'hE0, 8'h00, 0, 0, 0, 1, 0});
    vecs.push_back('{4'd12, 8'h7F, 8'h00, 8'h80, 8'h00, 0, 0, 1, 1, 0});
    vecs.push_back('{4'd12, 8'hFF, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 0});
    vecs.push_back('{4'd10, 8'h81, 8'h01, 8'hC0, 8'h00, 0, 1, 0, 1, 0});
    vecs.push_back('{4'd8,  8'h81, 8'h01, 8'h02, 8'h00, 0, 1, 0, 0, 0});
    vecs.push_back('{4'd9,  8'h81, 8'h01, 8'h40, 8'h00, 0, 1, 0, 0, 0});
    vecs.push_back('{4'd1,  8'h80, 8'h01, 8'h7F, 8'h00, 0, 0, 1, 0, 0});
    vecs.push_back('{4'd11, 8'h05, 8'h09, 8'h01, 8'h00, 0, 1, 0, 0, 0});
    vecs.push_back('{4'd15, 8'hE1, 8'h00, 8'hFF, 8'hE1, 0, 0, 0, 1, 1});
    vecs.push_back('{4'd0,  8'h03, 8'h04, 8'h07, 8'h00, 0, 0, 0, 0, 0});

    // reset state, held in reset
    #1;
    chk("rst_in_ready", 16'(in_ready), 16'd1);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_r", 16'(r), 16'd0);
    chk("rst_r_hi", 16'(r_hi), 16'd0);
    chk("rst_flags", 16'({zf, cf, vf, nf, err}), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // single-cycle ops: result visible one cycle after accept
    foreach (vecs[i]) begin
      do_accept(vecs[i].op, vecs[i].a, vecs[i].b);
      chk($sformatf("v%0d_op%0d_out_valid", i, vecs[i].op), 16'(out_valid), 16'd1);
      chk($sformatf("v%0d_op%0d_r", i, vecs[i].op), 16'(r), 16'(vecs[i].r));
      chk($sformatf("v%0d_op%0d_r_hi", i, vecs[i].op), 16'(r_hi), 16'(vecs[i].rh));
      chk($sformatf("v%0d_op%0d_zf", i, vecs[i].op), 16'(zf), 16'(vecs[i].zf));
      chk($sformatf("v%0d_op%0d_cf", i, vecs[i].op), 16'(cf), 16'(vecs[i].cf));
      chk($sformatf("v%0d_op%0d_vf", i, vecs[i].op), 16'(vf), 16'(vecs[i].vf));
      chk($sformatf("v%0d_op%0d_nf", i, vecs[i].op), 16'(nf), 16'(vecs[i].nf));
      chk($sformatf("v%0d_op%0d_err", i, vecs[i].op), 16'(err), 16'(vecs[i].err));
      release_out();
    end

    // MUL 225*200 = 0xAFC8, with a stray in_valid pulse mid-operation
    do_accept(4'd14, 8'hE1, 8'hC8);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      chk($sformatf("mul_busy_c%0d_out_valid", cyc), 16'(out_valid), 16'd0);
      chk($sformatf("mul_busy_c%0d_in_ready", cyc), 16'(in_ready), 16'd0);
      if (cyc == 3) begin
        in_valid = 1'b1; op = 4'd0; a = 8'h11; b = 8'h22;
      end
      if (cyc == 4) in_valid = 1'b0;
      @(negedge clk);
    end
    chk("mul_out_valid_c9", 16'(out_valid), 16'd1);
    chk("mul_r", 16'(r), 16'hC8);
    chk("mul_r_hi", 16'(r_hi), 16'hAF);
    chk("mul_flags", 16'({zf, cf, vf, nf, err}), 16'b01010);

    // backpressure: result and flags hold for 5 cycles
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_out_valid", k), 16'(out_valid), 16'd1);
      chk($sformatf("bp%0d_in_ready", k), 16'(in_ready), 16'd0);
      chk($sformatf("bp%0d_r", k), 16'({r_hi, r}), 16'hAFC8);
      chk($sformatf("bp%0d_flags", k), 16'({zf, cf, vf, nf, err}), 16'b01010);
    end
    release_out();

    // DIV 225/200 = 1 rem 25
    do_accept(4'd15, 8'hE1, 8'hC8);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      chk($sformatf("div_busy_c%0d_out_valid", cyc), 16'(out_valid), 16'd0);
      @(negedge clk);
    end
    chk("div_out_valid_c9", 16'(out_valid), 16'd1);
    chk("div_r", 16'(r), 16'd1);
    chk("div_r_hi", 16'(r_hi), 16'd25);
    chk("div_flags", 16'({zf, cf, vf, nf, err}), 16'b00000);
    release_out();

    // async reset in the 4th BUSY cycle of a MUL
    do_accept(4'd14, 8'hE1, 8'hC8);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 16'(out_valid), 16'd0);
    chk("arst_r", 16'(r), 16'd0);
    chk("arst_r_hi", 16'(r_hi), 16'd0);
    chk("arst_in_ready", 16'(in_ready), 16'd1);
    in_valid = 1'b1; op = 4'd0; a = 8'h09; b = 8'h09;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;
    chk("arst_no_capture", 16'(out_valid), 16'd0);
    chk("arst_r_still_0", 16'(r), 16'd0);

    do_accept(4'd0, 8'd3, 8'd4);
    chk("post_rst_add_valid", 16'(out_valid), 16'd1);
    chk("post_rst_add_r", 16'(r), 16'd7);
    chk("post_rst_add_flags", 16'({zf, cf, vf, nf, err}), 16'b00000);
    release_out();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
